// File: rtl/text_banner_reader_pkg.sv
// text_banner_reader_pkg: banner geometry, colours and FSM encoding shared with ROM and RGB mux
package text_banner_reader_pkg;
   localparam int WIDTH = 210;
   localparam int ROWS = 25;
   localparam int X0 = 215;
   localparam int Y0 = 40;
   localparam logic [7:0] FG_RGB = 8'hFF;
   localparam logic [7:0] BG_RGB = 8'h00;
   typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, SHIFT = 2'b10} state_t;
endpackage

// File: rtl/text_row_shifter.sv
// text_row_shifter: parallel-load MSB-first shift register with bit counter
module text_row_shifter #(
   parameter int WIDTH = text_banner_reader_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb,
   output logic             last
);
   logic [WIDTH-1:0] sreg;
   logic [7:0] count;
   always_ff @(posedge clk) begin
      if (reset) begin
         sreg <= '0;
         count <= '0;
      end else if (load) begin
         sreg <= din;
         count <= '0;
      end else if (shift) begin
         sreg <= sreg << 1;
         count <= count + 8'd1;
      end
   end
   assign msb = sreg[WIDTH-1];
   assign last = count == 8'(WIDTH - 1);
endmodule

// File: rtl/text_banner_reader.sv
// text_banner_reader: fetches one bitmap ROM row per banner line and streams it as text_on/rgb_text
module text_banner_reader
   import text_banner_reader_pkg::*;
#(
   parameter int X0 = text_banner_reader_pkg::X0,
   parameter int Y0 = text_banner_reader_pkg::Y0,
   parameter int WIDTH = text_banner_reader_pkg::WIDTH,
   parameter int ROWS = text_banner_reader_pkg::ROWS,
   parameter logic [7:0] FG_RGB = text_banner_reader_pkg::FG_RGB,
   parameter logic [7:0] BG_RGB = text_banner_reader_pkg::BG_RGB
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pixel_tick,
   input  logic             video_on,
   input  logic [9:0]       pixel_x,
   input  logic [9:0]       pixel_y,
   output logic [7:0]       rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic             text_on,
   output logic [7:0]       rgb_text
);
   localparam logic [9:0] X_TRIG = 10'(X0 - 2);
   localparam logic [9:0] Y_TOP = 10'(Y0);
   localparam logic [9:0] Y_END = 10'(Y0 + ROWS);
   state_t state, state_nx;
   logic [7:0] addr_nx, row;
   logic row_in, load, shift, msb, last, text_nx;
   assign row_in = (pixel_y >= Y_TOP) && (pixel_y < Y_END);
   assign row = pixel_y[7:0] - Y_TOP[7:0];
   text_row_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk(clk), .reset(reset), .load(load), .shift(shift),
      .din(rom_data), .msb(msb), .last(last)
   );
   always_comb begin
      state_nx = state;
      addr_nx = rom_addr;
      load = 1'b0;
      shift = 1'b0;
      text_nx = 1'b0;
      if (pixel_tick) begin
         case (state)
            IDLE: if (row_in && pixel_x == X_TRIG) begin
               addr_nx = row;
               state_nx = FETCH;
            end
            FETCH: begin
               load = 1'b1;
               state_nx = SHIFT;
            end
            SHIFT: begin
               shift = 1'b1;
               text_nx = msb & video_on;
               state_nx = last ? IDLE : SHIFT;
            end
            default: state_nx = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rom_addr <= '0;
         text_on <= 1'b0;
         rgb_text <= BG_RGB;
      end else if (pixel_tick) begin
         state <= state_nx;
         rom_addr <= addr_nx;
         text_on <= text_nx;
         rgb_text <= text_nx ? FG_RGB : BG_RGB;
      end
   end
endmodule

// File: tb/tb_text_banner_reader.sv
// tb_text_banner_reader: directed line-by-line checks of banner rendering against a bench ROM model
module tb_text_banner_reader;
   logic clk = 0, reset = 1, pixel_tick = 0, video_on = 1;
   logic [9:0] pixel_x = '0, pixel_y = '0;
   logic [7:0] rom_addr, rgb_text;
   logic [209:0] rom_data;
   logic text_on, force_ones = 0;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   function automatic logic [209:0] rom_row(input logic [7:0] r);
      logic [215:0] t;
      t = {27{r}};
      return t[209:0];
   endfunction

   assign rom_data = force_ones ? '1 : rom_row(rom_addr);

   text_banner_reader dut (
      .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .rom_addr(rom_addr), .rom_data(rom_data),
      .text_on(text_on), .rgb_text(rgb_text)
   );

   task automatic tick(input int x);
      @(negedge clk);
      pixel_x = 10'(x);
      pixel_tick = 1;
      @(negedge clk);
      pixel_tick = 0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Sweeps one line; after the tick at x the outputs must show bit (424-x) of the row.
   task automatic render_line(input int y, input int xs, input logic draw, input logic [209:0] bits,
                              input logic [7:0] end_addr, input int vo_lo, input int vo_hi,
                              input int rst_x, input int stall_x, input string tag);
      logic exp, hold;
      int bad;
      bad = 0;
      pixel_y = 10'(y);
      for (int x = xs; x <= 430; x++) begin
         video_on = !(x >= vo_lo && x <= vo_hi);
         if (x == rst_x) begin
            @(negedge clk);
            reset = 1;
            @(negedge clk);
            reset = 0;
         end
         tick(x);
         exp = (draw && x >= 215 && x <= 424 && x < rst_x) ? bits[424 - x] & video_on : 1'b0;
         tests++;
         if (text_on !== exp || rgb_text !== (exp ? 8'hFF : 8'h00)) begin
            fails++;
            if (bad++ < 4)
               $display("FAIL %s y=%0d x=%0d text_on=%b rgb=%h required text_on=%b rgb=%h",
                        tag, y, x, text_on, rgb_text, exp, exp ? 8'hFF : 8'h00);
         end
         if (x == stall_x) begin
            hold = text_on;
            repeat (20) @(negedge clk);
            tests++;
            if (text_on !== hold) begin
               fails++;
               $display("FAIL %s_stall text_on=%b required %b", tag, text_on, hold);
            end
         end
      end
      video_on = 1;
      tests++;
      if (rom_addr !== end_addr) begin
         fails++;
         $display("FAIL %s_addr rom_addr=%h required %h", tag, rom_addr, end_addr);
      end
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (10) @(negedge clk);
      reset = 0;
      tests++;
      if (text_on !== 1'b0 || rgb_text !== 8'h00 || rom_addr !== 8'h00) begin
         fails++;
         $display("FAIL reset text_on=%b rgb=%h addr=%h required 0/00/00", text_on, rgb_text, rom_addr);
      end
      render_line(10, 200, 0, '0, 8'h00, -1, -1, 9999, -1, "pre_banner");
   endtask

   task automatic test_first_line;
      render_line(40, 200, 1, rom_row(8'h00), 8'h00, -1, -1, 9999, -1, "line40");
      render_line(42, 200, 1, rom_row(8'h02), 8'h02, -1, -1, 9999, -1, "line42");
   endtask

   task automatic test_boundaries;
      render_line(64, 200, 1, rom_row(8'h18), 8'h18, -1, -1, 9999, -1, "line64");
      render_line(65, 200, 0, '0, 8'h18, -1, -1, 9999, -1, "line65");
      render_line(39, 200, 0, '0, 8'h18, -1, -1, 9999, -1, "line39");
      render_line(41, 214, 0, '0, 8'h18, -1, -1, 9999, -1, "skip_trigger");
   endtask

   task automatic test_video_gap;
      force_ones = 1;
      render_line(45, 200, 1, '1, 8'h05, 300, 309, 9999, -1, "video_gap");
      force_ones = 0;
   endtask

   task automatic test_reset_mid;
      render_line(50, 200, 1, rom_row(8'h0a), 8'h00, -1, -1, 300, -1, "reset_mid");
      render_line(51, 200, 1, rom_row(8'h0b), 8'h0b, -1, -1, 9999, -1, "after_reset");
   endtask

   task automatic test_stall;
      render_line(60, 200, 1, rom_row(8'h14), 8'h14, -1, -1, 9999, 320, "stall");
   endtask

   initial begin
      test_reset;
      test_first_line;
      test_boundaries;
      test_video_gap;
      test_reset_mid;
      test_stall;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
